mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MIPS32 MEM stage, directly downstream of the EX/MEM pipeline register.
//  - Performs the data-memory load/store using an internal word-addressed RAM with a configurable access latency.
//  - Resolves branch/jump redirection and tells the front end to flush.
//  - Stalls upstream while a memory access is outstanding.
//  - Registers the results into the MEM/WB fields.
// PARAMETERS
//  DEPTH    1024  data memory size in 32-bit words (power of 2)
//  ADDR_W   10    log2(DEPTH); word index = in_alu_result[ADDR_W+1:2]
//  MEM_LAT  2     extra cycles per load/store (0 = single-cycle access)
// PORTS
//  clk               in   1   clock, all state on posedge
//  rst               in   1   synchronous reset, active-high
//  in_valid          in   1   EX/MEM holds a live instruction
//  in_alu_result     in   32  ALU result / memory byte address
//  in_store_data     in   32  store data (rt value)
//  in_dest_reg       in   5   destination register
//  in_branch         in   1   beq control
//  in_zf             in   1   ALU zero flag
//  in_branch_target  in   32  PC+4+offset<<2
//  in_jump           in   1   jump control
//  in_jump_target    in   32  jump target
//  in_mem_read       in   1   load
//  in_mem_write      in   1   store
//  in_reg_write      in   1   writes register file
//  in_mem_to_reg     in   1   WB selects memory data
//  stall             out  1   freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
//  pc_src            out  1   redirect PC this cycle (combinational)
//  pc_target         out  32  redirect address
//  flush             out  1   squash IF/ID and ID/EX (== pc_src)
//  out_valid         out  1   MEM/WB holds a live instruction
//  out_read_data     out  32  load data
//  out_alu_result    out  32  ALU result passthrough
//  out_dest_reg      out  5   destination register
//  out_reg_write     out  1   WB enable (qualified by out_valid)
//  out_mem_to_reg    out  1   WB mux select
// BEHAVIOUR
//  - mem_op = in_valid & (in_mem_read | in_mem_write).
//  - FSM states:
//    - IDLE: if mem_op && MEM_LAT>0 -> WAIT with cnt=MEM_LAT-1; otherwise stay in IDLE.
//    - WAIT: if cnt!=0, decrement cnt; if cnt==0, commit and go to IDLE.
//  - stall = (IDLE & mem_op & MEM_LAT!=0) | (WAIT & cnt!=0).
//    - A load/store therefore holds the stage for MEM_LAT+1 cycles with stall high for MEM_LAT of them.
//  - commit = in_valid & ~stall.
//    - On the commit edge, the MEM/WB fields capture the inputs and out_valid<=1.
//    - In any other cycle, out_valid<=0 and out_reg_write<=0; the remaining fields hold.
//  - Store: mem[idx] <= in_store_data on the commit edge only.
//  - Load: out_read_data <= mem[idx] on the commit edge.
//    - For a non-load commit, out_read_data <= 0.
//  - If in_mem_read and in_mem_write are both set, the store wins and out_read_data <= 0.
//  - Addresses beyond DEPTH wrap: upper address bits are ignored.
//  - Redirect:
//    - pc_src = commit & (in_jump | (in_branch & in_zf)).
//    - Jump has priority: pc_target = in_jump ? in_jump_target : in_branch_target.
//    - pc_target is don't-care when pc_src=0.
//    - Redirect is never asserted while stall=1.
//  - Reset: state=IDLE, cnt=0, out_valid=0, out_reg_write=0, out_mem_to_reg=0.
//    - out_read_data, out_alu_result and out_dest_reg reset to 0.
//    - No commit or memory write occurs in a reset cycle.
//    - Memory contents are not reset.
//    - Reset during WAIT abandons the access and discards the pending store.
//  - Back-to-back memory ops each take the full latency; there is no pipelining inside the stage.
// CONFIGURATION
//  MEM_STAGE_ALIGN_TRAP_EN
//  - Defined:
//    - Adds output out_misaligned (1 bit, reset 0), registered on the commit edge.
//    - out_misaligned = mem_op & (in_alu_result[1:0]!=0).
//    - A misaligned access suppresses the memory write and forces out_reg_write<=0.
//    - The latency and stall timing are unchanged.
//  - Undefined:
//    - The port is absent and in_alu_result[1:0] is ignored.
//    - Every access is treated as an aligned word access.
// TESTING
//  1. MEM_LAT=2. Store 0xDEADBEEF to addr 0x10, then load from 0x10 -> stall high 2 cycles per op; load commit gives out_read_data=0xDEADBEEF, out_reg_write=1.
//  2. R-type (no mem op), reg_write=1, dest=5, alu=0x1234 -> no stall; the next edge gives out_valid=1, out_alu_result=0x1234, out_dest_reg=5.
//  3. Branch=1, zf=1, target=0x40 -> pc_src=flush=1, pc_target=0x40 in the same cycle; with zf=0, pc_src=0.
//  4. Jump=1 and branch=1/zf=1, jump_target=0x80 -> pc_target=0x80.
//  5. Store to 0x20 with rst pulsed in the second WAIT cycle -> stall drops, out_valid=0; a later load of 0x20 returns the old contents.
//  6. ALIGN_TRAP_EN: store to 0x22 -> out_misaligned=1 and memory unchanged. Without the macro: word 8 (addr 0x20) is written.
//  7. MEM_LAT=0, load at addr 0x1000 with DEPTH=1024 -> no stall; reads mem[0] (wrap).

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MIPS32 MEM stage that sits downstream of the EX/MEM register.
// It does the data-memory load/store into an internal word RAM with
// MEM_LAT extra cycles of access latency, resolves branch/jump redirects,
// stalls the upstream stages while an access is in progress, and registers
// the MEM/WB fields.
//
// Optional feature macro: MEM_STAGE_ALIGN_TRAP_EN
//   defined   -> adds output out_misaligned; a misaligned access does not
//                write memory and clears out_reg_write.
//   undefined -> in_alu_result[1:0] is ignored and every access is treated
//                as an aligned word access.

module mem_stage #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_dest_reg,
  input  logic        in_branch,
  input  logic        in_zf,
  input  logic [31:0] in_branch_target,
  input  logic        in_jump,
  input  logic [31:0] in_jump_target,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic        in_reg_write,
  input  logic        in_mem_to_reg,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        out_valid,
  output logic [31:0] out_read_data,
  output logic [31:0] out_alu_result,
  output logic [4:0]  out_dest_reg,
  output logic        out_reg_write,
  output logic        out_mem_to_reg
`ifdef MEM_STAGE_ALIGN_TRAP_EN
  ,
  output logic        out_misaligned
`endif
);

  // The wait counter only has to hold MEM_LAT-1.
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam bit          LAT_EN = (MEM_LAT != 0);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MEM_LAT > 0) ? (MEM_LAT - 1) : 0);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              mem_op;
  logic              commit;
  logic              misaligned;
  logic              load_sel;
  logic              mem_we;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;

  logic [31:0] mem [DEPTH];

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_read_data_q, out_read_data_d;
  logic [31:0] out_alu_result_q, out_alu_result_d;
  logic [4:0]  out_dest_reg_q, out_dest_reg_d;
  logic        out_reg_write_q, out_reg_write_d;
  logic        out_mem_to_reg_q, out_mem_to_reg_d;
  logic        out_misaligned_q, out_misaligned_d;

  // Upper address bits wrap (ignored); byte-offset bits only matter for the trap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{in_alu_result[31:ADDR_W+2], in_alu_result[1:0]};

  // Decode the incoming instruction: memory op, word index, load vs store.
  always_comb begin
    mem_op   = in_valid & (in_mem_read | in_mem_write);
    idx      = in_alu_result[ADDR_W+1:2];
    // A simultaneous read+write behaves as a store; read data is zero.
    load_sel = in_mem_read & ~in_mem_write;
`ifdef MEM_STAGE_ALIGN_TRAP_EN
    misaligned = mem_op & (in_alu_result[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  // Latency FSM: IDLE launches an access, WAIT counts down and then commits.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op && LAT_EN) begin
          stall   = 1'b1;
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Commit qualification and PC redirect; redirect can only fire on commit.
  always_comb begin
    commit    = in_valid & ~stall;
    pc_src    = commit & (in_jump | (in_branch & in_zf));
    pc_target = in_jump ? in_jump_target : in_branch_target;
    flush     = pc_src;
    mem_we    = commit & in_mem_write & ~misaligned & ~rst;
  end

  // Asynchronous read of the addressed word, sampled only on the commit edge.
  always_comb begin
    rd_word = mem[idx];
  end

  // Data memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= in_store_data;
    end
  end

  // MEM/WB next values: capture on commit, otherwise drop valid/reg_write and hold.
  always_comb begin
    out_valid_d      = 1'b0;
    out_reg_write_d  = 1'b0;
    out_read_data_d  = out_read_data_q;
    out_alu_result_d = out_alu_result_q;
    out_dest_reg_d   = out_dest_reg_q;
    out_mem_to_reg_d = out_mem_to_reg_q;
    out_misaligned_d = out_misaligned_q;
    if (commit) begin
      out_valid_d      = 1'b1;
      out_reg_write_d  = in_reg_write & ~misaligned;
      out_read_data_d  = load_sel ? rd_word : '0;
      out_alu_result_d = in_alu_result;
      out_dest_reg_d   = in_dest_reg;
      out_mem_to_reg_d = in_mem_to_reg;
      out_misaligned_d = misaligned;
    end
  end

  // State and pipeline registers with synchronous reset; reset blocks any commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      out_valid_q      <= 1'b0;
      out_read_data_q  <= '0;
      out_alu_result_q <= '0;
      out_dest_reg_q   <= '0;
      out_reg_write_q  <= 1'b0;
      out_mem_to_reg_q <= 1'b0;
      out_misaligned_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      out_valid_q      <= out_valid_d;
      out_read_data_q  <= out_read_data_d;
      out_alu_result_q <= out_alu_result_d;
      out_dest_reg_q   <= out_dest_reg_d;
      out_reg_write_q  <= out_reg_write_d;
      out_mem_to_reg_q <= out_mem_to_reg_d;
      out_misaligned_q <= out_misaligned_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_read_data  = out_read_data_q;
  assign out_alu_result = out_alu_result_q;
  assign out_dest_reg   = out_dest_reg_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_mem_to_reg = out_mem_to_reg_q;

`ifdef MEM_STAGE_ALIGN_TRAP_EN
  assign out_misaligned = out_misaligned_q;
`else
  logic unused_misaligned;
  assign unused_misaligned = out_misaligned_q;
`endif

endmodule
